// File: rtl/sp_sync_ram_be.sv
// rtl/sp_sync_ram_be.sv - single-port synchronous RAM with byte enables, selectable read-during-write and post-reset clear
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; restarts the clear sequence
//   en         access request (ignored while busy)
//   we         write qualifier, valid with en
//   be         per-byte write enables, bit i covers din[8i+7:8i]
//   addr       word address
//   din        write data
//   dout       registered read data (1-cycle latency)
//   dout_valid dout was updated by the access of the previous cycle
//   busy       clear sequence in progress
//   par_inj    (SPRAM_PARITY_EN only) invert stored parity of enabled bytes on write
//   par_err    (SPRAM_PARITY_EN only) read word failed its parity check, valid with dout_valid
//
// Optional feature: define SPRAM_PARITY_EN to add one even-parity bit per byte.

module sp_sync_ram_be #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 4,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   din,
  output logic [DATA_W-1:0]   dout,
  output logic                dout_valid,
  output logic                busy
`ifdef SPRAM_PARITY_EN
  ,
  input  logic                par_inj,
  output logic                par_err
`endif
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [ADDR_W-1:0]   clr_cnt_next;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Single write port shared by the clear sequence and user writes.
  logic                acc;
  logic [NB-1:0]       wr_be;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;

  logic [DATA_W-1:0]   rd_old;
  logic [DATA_W-1:0]   rd_merged;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and write-port steering
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    acc          = 1'b0;
    wr_be        = '0;
    wr_addr      = addr;
    wr_data      = din;
    case (state)
      ST_CLEAR: begin
        wr_be        = '1;
        wr_addr      = clr_cnt;
        wr_data      = '0;
        clr_cnt_next = clr_cnt + ADDR_W'(1);
        if (clr_cnt == '1) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        acc = en;
        if (en && we) begin
          wr_be = be;
        end
      end
    endcase
    // An edge that sees reset must not commit any write.
    if (rst) begin
      wr_be = '0;
      acc   = 1'b0;
    end
  end

  assign busy = (state == ST_CLEAR);

  // ---------------------------------------------------------------------------
  // Read path: old word and the word as it will look after this edge's write
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_old    = mem[addr];
    rd_merged = rd_old;
    for (int i = 0; i < NB; i++) begin
      if (we && be[i]) begin
        rd_merged[8*i +: 8] = din[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) begin
        mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (acc) begin
      dout       <= (RDW_MODE != 0) ? rd_merged : rd_old;
      dout_valid <= 1'b1;
    end else begin
      dout_valid <= 1'b0;
    end
  end

`ifdef SPRAM_PARITY_EN
  // ---------------------------------------------------------------------------
  // Per-byte even parity; clear writes parity 0, which is correct for a 0 byte.
  // ---------------------------------------------------------------------------
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] wr_par;
  logic [NB-1:0] rd_par_old;
  logic [NB-1:0] rd_par_merged;
  logic          perr_old;
  logic          perr_merged;

  always_comb begin
    wr_par        = '0;
    rd_par_old    = par_mem[addr];
    rd_par_merged = rd_par_old;
    perr_old      = 1'b0;
    perr_merged   = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (state != ST_CLEAR) begin
        wr_par[i] = (^din[8*i +: 8]) ^ par_inj;
      end
      if (we && be[i]) begin
        rd_par_merged[i] = wr_par[i];
      end
      perr_old    = perr_old    | ((^rd_old[8*i +: 8])    ^ rd_par_old[i]);
      perr_merged = perr_merged | ((^rd_merged[8*i +: 8]) ^ rd_par_merged[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) begin
        par_mem[wr_addr][i] <= wr_par[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      par_err <= 1'b0;
    end else if (acc) begin
      par_err <= (RDW_MODE != 0) ? perr_merged : perr_old;
    end else begin
      par_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sp_sync_ram_be.sv
// tb/tb_sp_sync_ram_be.sv - self-checking bench for sp_sync_ram_be (read-first and write-first instances)

module tb_sp_sync_ram_be;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        we  = 1'b0;
  logic [1:0]  be  = 2'b00;
  logic [3:0]  addr = 4'd0;
  logic [15:0] din = 16'd0;

  logic [15:0] dout0, dout1;
  logic        dv0, dv1, busy0, busy1;
`ifdef SPRAM_PARITY_EN
  logic        par_inj = 1'b0;
  logic        perr0, perr1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sp_sync_ram_be #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .din(din),
    .dout(dout0), .dout_valid(dv0), .busy(busy0)
`ifdef SPRAM_PARITY_EN
    , .par_inj(par_inj), .par_err(perr0)
`endif
  );

  sp_sync_ram_be #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .addr(addr), .din(din),
    .dout(dout1), .dout_valid(dv1), .busy(busy1)
`ifdef SPRAM_PARITY_EN
    , .par_inj(par_inj), .par_err(perr1)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: clear is a countdown; when it expires the whole array is zero.
  logic [15:0] mmem [16];
  logic [1:0]  mcor [16];
  int          clr_left = 0;
  logic        chk_on   = 1'b0;
  logic [15:0] e_dout0 = 16'd0, e_dout1 = 16'd0;
  logic        e_valid = 1'b0;
  logic        e_perr0 = 1'b0, e_perr1 = 1'b0;

  initial begin
    forever begin
      logic [15:0] old, mrg;
      logic [1:0]  oc, nc;
      @(posedge clk);
      if (rst) begin
        e_dout0 = 16'd0; e_dout1 = 16'd0; e_valid = 1'b0;
        e_perr0 = 1'b0;  e_perr1 = 1'b0;
        clr_left = 16;
        chk_on = 1'b1;
      end else if (clr_left > 0) begin
        clr_left--;
        e_valid = 1'b0; e_perr0 = 1'b0; e_perr1 = 1'b0;
        if (clr_left == 0) begin
          for (int k = 0; k < 16; k++) begin
            mmem[k] = 16'd0;
            mcor[k] = 2'b00;
          end
        end
      end else if (en) begin
        old = mmem[addr];
        oc  = mcor[addr];
        mrg = old;
        nc  = oc;
        if (we) begin
          for (int b = 0; b < 2; b++) begin
            if (be[b]) begin
              mrg[8*b +: 8] = din[8*b +: 8];
`ifdef SPRAM_PARITY_EN
              nc[b] = par_inj;
`else
              nc[b] = 1'b0;
`endif
            end
          end
        end
        e_dout0 = old;
        e_dout1 = mrg;
        e_perr0 = |oc;
        e_perr1 = |nc;
        e_valid = 1'b1;
        mmem[addr] = mrg;
        mcor[addr] = nc;
      end else begin
        e_valid = 1'b0; e_perr0 = 1'b0; e_perr1 = 1'b0;
      end
    end
  end

  // Compare process: every cycle after the first reset.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("busy0", busy0, (clr_left > 0));
        chk("busy1", busy1, (clr_left > 0));
        chk("dv0", dv0, e_valid);
        chk("dv1", dv1, e_valid);
        chk("dout0", dout0, e_dout0);
        chk("dout1", dout1, e_dout1);
`ifdef SPRAM_PARITY_EN
        chk("perr0", perr0, e_perr0);
        chk("perr1", perr1, e_perr1);
`endif
      end
    end
  end

  // Apply inputs at a falling edge; return at the next falling edge with the result visible.
  task automatic step(input logic r, input logic e, input logic w, input logic [1:0] b,
                      input logic [3:0] a, input logic [15:0] d, input logic pi);
    rst = r; en = e; we = w; be = b; addr = a; din = d;
`ifdef SPRAM_PARITY_EN
    par_inj = pi;
`else
    if (pi) begin
      din = d;
    end
`endif
    @(negedge clk);
  endtask

  task automatic count_busy(input string name);
    int cnt;
    cnt = 0;
    // Requests issued while busy target addr 7 and must be dropped.
    while (busy0 && cnt < 100) begin
      step(1'b0, 1'b1, 1'b1, 2'b11, 4'd7, 16'hFFFF, 1'b0);
      cnt++;
    end
    chk(name, cnt, 16);
  endtask

  initial begin
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 16'd0, 1'b0);
    chk("busy_after_rst", busy0, 1'b1);
    chk("dv_after_rst", dv0, 1'b0);
    chk("dout_after_rst", dout0, 16'h0000);
    count_busy("clear_cycles");

    for (int a = 0; a < 16; a++) begin
      step(1'b0, 1'b1, 1'b0, 2'b00, 4'(a), 16'd0, 1'b0);
      chk("clear_read_dout", dout0, 16'h0000);
      chk("clear_read_dv", dv0, 1'b1);
    end

    step(1'b0, 1'b1, 1'b1, 2'b11, 4'd3, 16'hAABB, 1'b0);
    step(1'b0, 1'b1, 1'b1, 2'b01, 4'd3, 16'h1122, 1'b0);
    chk("be_rdw1_merge", dout1, 16'hAA22);
    step(1'b0, 1'b1, 1'b0, 2'b00, 4'd3, 16'd0, 1'b0);
    chk("be_read0", dout0, 16'hAA22);
    chk("be_read1", dout1, 16'hAA22);

    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 16'd0, 1'b0);
      chk("idle_hold", dout0, 16'hAA22);
      chk("idle_dv", dv0, 1'b0);
    end

    step(1'b0, 1'b1, 1'b0, 2'b00, 4'd7, 16'd0, 1'b0);
    chk("busy_write_dropped", dout0, 16'h0000);

    step(1'b0, 1'b1, 1'b1, 2'b11, 4'd5, 16'h1234, 1'b0);
    step(1'b0, 1'b1, 1'b1, 2'b11, 4'd5, 16'hBEEF, 1'b0);
    chk("rdw_read_first", dout0, 16'h1234);
    chk("rdw_write_first", dout1, 16'hBEEF);
    step(1'b0, 1'b1, 1'b1, 2'b00, 4'd5, 16'h0000, 1'b0);
    chk("rdw_after0", dout0, 16'hBEEF);
    chk("rdw_after1", dout1, 16'hBEEF);

`ifdef SPRAM_PARITY_EN
    step(1'b0, 1'b1, 1'b1, 2'b11, 4'd9, 16'h00FF, 1'b1);
    step(1'b0, 1'b1, 1'b0, 2'b00, 4'd9, 16'd0, 1'b0);
    chk("par_inj_dout", dout0, 16'h00FF);
    chk("par_inj_err", perr0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 2'b11, 4'd9, 16'h00FF, 1'b0);
    step(1'b0, 1'b1, 1'b0, 2'b00, 4'd9, 16'd0, 1'b0);
    chk("par_clean_err", perr0, 1'b0);
`endif

    step(1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 16'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 16'd0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 16'd0, 1'b0);
    count_busy("midclear_cycles");
    for (int a = 0; a < 16; a++) begin
      step(1'b0, 1'b1, 1'b0, 2'b00, 4'(a), 16'd0, 1'b0);
      chk("midclear_read", dout1, 16'h0000);
    end

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           2'($urandom), 4'($urandom), 16'($urandom), ($urandom_range(0, 7) == 0));
    end
    step(1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 16'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sp_sync_ram_be.md
Name: sp_sync_ram_be

Overview:
- Next-generation single-port synchronous RAM: parametrised data width and depth, per-byte write enables and a selectable read-during-write mode.
- Includes a built-in clear state machine that zeroes every word after reset.
- Used as the generic scratch or buffer memory in the memory library. One access per cycle; read latency is 1 cycle.

Parameters:
- DATA_W, 16, data word width in bits; must be a multiple of 8.
- ADDR_W, 4, address width; depth DEPTH = 2**ADDR_W words (localparam).
- RDW_MODE, 0, read-during-write result: 0 = read-first (old word), 1 = write-first (merged new word).
- CLEAR_ON_RESET, 1, 1 = zero all DEPTH words after reset; 0 = no clear, memory contents undefined.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  access request, sampled on the rising edge.
- we  input  1  write qualifier, valid when en=1.
- be  input  DATA_W/8  byte enables for writes; bit i covers din[8i+7:8i].
- addr  input  ADDR_W  word address.
- din  input  DATA_W  write data.
- dout  output  DATA_W  registered read data.
- dout_valid  output  1  dout was updated by the access in the previous cycle.
- busy  output  1  clear in progress; requests are ignored while high.

Behaviour:
- Reset (rst=1 at an edge):
  - dout<=0, dout_valid<=0, clear counter<=0.
  - State<=CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - busy<=1 if CLEAR_ON_RESET=1, else 0.
  - Reset asserted mid-clear or mid-access restarts the clear from address 0. No partial write from that edge is committed.
- FSM states CLEAR and IDLE:
  - CLEAR: each edge writes 0 to mem[clr_cnt] and increments clr_cnt.
  - When clr_cnt reaches DEPTH-1 that write occurs, then state<=IDLE and busy<=0.
  - Clear takes exactly DEPTH cycles after the reset-release edge.
  - In CLEAR, en/we/be/addr/din are ignored and dout_valid stays 0.
- IDLE with en=1:
  - Every access reads mem[addr]. dout updates at that same edge and dout_valid=1 for the following cycle.
  - If we=1, each byte i with be[i]=1 is written from din. Bytes with be[i]=0 keep their old value.
  - we=1 with be=0 performs no write but still reads.
- Read-during-write (same edge, same address):
  - RDW_MODE=0: dout = pre-write word.
  - RDW_MODE=1: dout = merged word (din bytes where be=1, old bytes elsewhere).
- IDLE with en=0: no memory change, dout holds its last value, dout_valid<=0.
- Address wrap is not applicable: all 2**ADDR_W addresses are valid and no range check is needed.
- Back-to-back accesses are sustained every cycle with no bubbles.

Optional Feature:
- Macro SPRAM_PARITY_EN.
- When defined:
  - Each byte stores an extra even-parity bit, computed from the written byte (clear writes parity 0).
  - Extra input par_inj (1 bit): when 1 during a write, inverts the stored parity of every enabled byte.
  - Extra output par_err (1 bit): registered alongside dout and set if any byte of the read word fails its parity check. It is valid with dout_valid, resets to 0 and is 0 whenever dout_valid=0.
- When not defined: no parity storage and no par_inj/par_err ports; behaviour is otherwise identical.

Test Plan:
- Clear (CLEAR_ON_RESET=1, ADDR_W=4): pulse rst for 1 cycle -> busy=1 for exactly 16 cycles, then 0. Reading addr 0..15 returns 0x0000 with dout_valid=1 one cycle after each request.
- Byte enables: write addr 3 din=0xAABB be=2'b11, then din=0x1122 be=2'b01, then read addr 3 -> dout=0xAA22.
- Read-during-write: mem[5]=0x1234, then en=1 we=1 addr=5 din=0xBEEF be=2'b11 -> dout=0x1234 with RDW_MODE=0, 0xBEEF with RDW_MODE=1. A subsequent read of addr 5 returns 0xBEEF in both modes.
- Idle and ignored requests:
  - en=0 for 3 cycles after reading 0xAA22 -> dout stays 0xAA22, dout_valid=0.
  - A write to addr 7 issued while busy=1 -> mem[7] reads 0x0000 after the clear.
- Reset mid-clear: assert rst at clear cycle 8 -> busy stays high for 16 further cycles after release and all words read 0.
- Parity (SPRAM_PARITY_EN): write addr 9 0x00FF be=2'b11 par_inj=1 -> read gives dout=0x00FF, par_err=1. Rewrite with par_inj=0 -> par_err=0.
